// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline hazard control slice.
package mips_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO          = 5'd0;
  localparam int         MD_CYCLES_DEFAULT = 32;
  localparam int         MD_CNT_W          = 8;

  // Counter preload so that the countdown reaches zero in the cycle HI/LO is written
  function automatic logic [MD_CNT_W-1:0] md_load_value(input int cycles);
    return MD_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the multi-cycle MUL/DIV unit: issues the start pulse and counts down
// the latency so the hazard logic knows when HI/LO becomes valid.
module md_busy_tracker
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic id_ex_is_muldiv,
  output logic md_start,
  output logic md_busy,
  output logic md_pending
);

  md_state_e             state;
  logic [MD_CNT_W-1:0]   md_cnt;

  // Start/busy/pending are decoded straight from state so the stall has no latency
  always_comb begin
    md_start   = reset_n & (state == RUN) & id_ex_is_muldiv;
    md_busy    = reset_n & (state == MD_BUSY);
    md_pending = md_start | (md_busy & (md_cnt != '0));
  end

  // Operation FSM; a mul/div seen while busy is ignored rather than restarting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (id_ex_is_muldiv) begin
            state  <= MD_BUSY;
            md_cnt <= md_load_value(MD_CYCLES);
          end
        end
        MD_BUSY: begin
          if (md_cnt == '0) begin
            state <= RUN;
          end else begin
            md_cnt <= md_cnt - 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch flushes and a
// saturating stall-cycle performance counter.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int MD_CYCLES   = MD_CYCLES_DEFAULT,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4:0]             id_instr_rs,
  input  logic [4:0]             id_instr_rt,
  input  logic                   id_uses_rt,
  input  logic                   id_is_muldiv,
  input  logic                   id_reads_hilo,
  input  logic                   id_ex_mem_read,
  input  logic [4:0]             id_ex_write_reg_addr,
  input  logic                   id_ex_is_muldiv,
  input  logic                   ex_branch_taken,
  input  logic                   perf_clr,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   md_start,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic md_pending;
  logic load_use;
  logic md_hazard;
  logic stall;

  md_busy_tracker #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_busy_tracker (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_ex_is_muldiv (id_ex_is_muldiv),
    .md_start        (md_start),
    .md_busy         (md_busy),
    .md_pending      (md_pending)
  );

  // Hazard detection: a load feeding ID next cycle, or HI/LO/unit needed while busy
  always_comb begin
    load_use  = id_ex_mem_read & (id_ex_write_reg_addr != REG_ZERO) &
                ((id_ex_write_reg_addr == id_instr_rs) |
                 (id_uses_rt & (id_ex_write_reg_addr == id_instr_rt)));
    md_hazard = md_pending & (id_is_muldiv | id_reads_hilo);
    stall     = load_use | md_hazard;
  end

  // Pipeline enables; a taken branch wins because the stalled instruction is squashed
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    if (!reset_n) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end else if (stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end
  end

  // Saturating count of frozen-PC cycles; clear takes precedence over counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (!pc_write_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl with a 4-cycle MUL/DIV latency.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic       mr;
    logic [4:0] wa;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       idmd;
    logic       hilo;
    logic       exmd;
    logic       br;
    logic       clr;
  } stim_t;

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  id_instr_rs = '0;
  logic [4:0]  id_instr_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic        id_is_muldiv = 1'b0;
  logic        id_reads_hilo = 1'b0;
  logic        id_ex_mem_read = 1'b0;
  logic [4:0]  id_ex_write_reg_addr = '0;
  logic        id_ex_is_muldiv = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        perf_clr = 1'b0;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        md_start;
  logic        md_busy;
  logic [15:0] stall_cycles;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = '0;
  exp_t        sb[$];
  logic [5:0]  ctrl_obs;

  hazard_stall_ctrl #(
    .MD_CYCLES   (4),
    .STALL_CNT_W (16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .id_instr_rs          (id_instr_rs),
    .id_instr_rt          (id_instr_rt),
    .id_uses_rt           (id_uses_rt),
    .id_is_muldiv         (id_is_muldiv),
    .id_reads_hilo        (id_reads_hilo),
    .id_ex_mem_read       (id_ex_mem_read),
    .id_ex_write_reg_addr (id_ex_write_reg_addr),
    .id_ex_is_muldiv      (id_ex_is_muldiv),
    .ex_branch_taken      (ex_branch_taken),
    .perf_clr             (perf_clr),
    .pc_write_en          (pc_write_en),
    .if_id_write_en       (if_id_write_en),
    .if_id_flush          (if_id_flush),
    .id_ex_bubble         (id_ex_bubble),
    .md_start             (md_start),
    .md_busy              (md_busy),
    .stall_cycles         (stall_cycles)
  );

  always #5 clk = ~clk;

  // Control outputs packed as {pc_we, ifid_we, flush, bubble, md_start, md_busy}
  assign ctrl_obs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, md_start, md_busy};

  function automatic stim_t mk(input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt, input logic idmd,
                               input logic hilo, input logic exmd, input logic br,
                               input logic clr);
    stim_t s;
    s.mr = mr; s.wa = wa; s.rs = rs; s.rt = rt; s.urt = urt;
    s.idmd = idmd; s.hilo = hilo; s.exmd = exmd; s.br = br; s.clr = clr;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_ex_mem_read       = s.mr;
    id_ex_write_reg_addr = s.wa;
    id_instr_rs          = s.rs;
    id_instr_rt          = s.rt;
    id_uses_rt           = s.urt;
    id_is_muldiv         = s.idmd;
    id_reads_hilo        = s.hilo;
    id_ex_is_muldiv      = s.exmd;
    ex_branch_taken      = s.br;
    perf_clr             = s.clr;
  endtask

  // Counter reference model from the expected PC enable, then advance one cycle
  task automatic tick(input logic exp_pc);
    if (!reset_n) exp_cnt = '0;
    else if (perf_clr) exp_cnt = '0;
    else if (!exp_pc && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    sb.push_back('{"reset_hold", 6'b000100, exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
    total++;
    if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
    tick(e.ctrl[5]);
    reset_n = 1'b1;
    apply('0);
    sb.push_back('{"reset_release", 6'b110000, 16'd0});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
    total++;
    if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
    tick(e.ctrl[5]);
  endtask

  task automatic test_load_use();
    stim_t      st[8];
    logic [5:0] ex[8];
    exp_t       e;
    st[0] = mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[0] = 6'b000100;
    st[1] = '0;                                                              ex[1] = 6'b110000;
    st[2] = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[2] = 6'b110000;
    st[3] = mk(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[3] = 6'b110000;
    st[4] = mk(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[4] = 6'b000100;
    st[5] = mk(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[5] = 6'b000100;
    st[6] = mk(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[6] = 6'b110000;
    st[7] = '0;                                                              ex[7] = 6'b110000;
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      sb.push_back('{$sformatf("load_use_%0d", i), ex[i], exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
      total++;
      if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
      tick(e.ctrl[5]);
    end
  endtask

  task automatic test_muldiv();
    stim_t      st[18];
    logic [5:0] ex[18];
    exp_t       e;
    st[0]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ex[0]  = 6'b110010;
    st[1]  = '0;                                                              ex[1]  = 6'b110001;
    st[2]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ex[2]  = 6'b110001;
    st[3]  = '0;                                                              ex[3]  = 6'b110001;
    st[4]  = '0;                                                              ex[4]  = 6'b110001;
    st[5]  = '0;                                                              ex[5]  = 6'b110000;
    st[6]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); ex[6]  = 6'b000110;
    st[7]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); ex[7]  = 6'b000101;
    st[8]  = st[7];                                                           ex[8]  = 6'b000101;
    st[9]  = st[7];                                                           ex[9]  = 6'b000101;
    st[10] = st[7];                                                           ex[10] = 6'b110001;
    st[11] = st[7];                                                           ex[11] = 6'b110000;
    st[12] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); ex[12] = 6'b000110;
    st[13] = '0;                                                              ex[13] = 6'b110001;
    st[14] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ex[14] = 6'b000101;
    st[15] = '0;                                                              ex[15] = 6'b110001;
    st[16] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ex[16] = 6'b110001;
    st[17] = '0;                                                              ex[17] = 6'b110000;
    for (int i = 0; i < 18; i++) begin
      apply(st[i]);
      sb.push_back('{$sformatf("muldiv_%0d", i), ex[i], exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
      total++;
      if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
      tick(e.ctrl[5]);
    end
  endtask

  task automatic test_branch();
    stim_t      st[7];
    logic [5:0] ex[7];
    exp_t       e;
    st[0] = mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ex[0] = 6'b111100;
    st[1] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); ex[1] = 6'b111110;
    st[2] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); ex[2] = 6'b000101;
    st[3] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); ex[3] = 6'b111101;
    st[4] = '0;                                                              ex[4] = 6'b110001;
    st[5] = '0;                                                              ex[5] = 6'b110001;
    st[6] = '0;                                                              ex[6] = 6'b110000;
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      sb.push_back('{$sformatf("branch_%0d", i), ex[i], exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
      total++;
      if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
      tick(e.ctrl[5]);
    end
  endtask

  task automatic test_counter();
    stim_t      st[5];
    logic [5:0] ex[5];
    exp_t       e;
    stim_t      lu;
    lu = mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    tick(1'b0);
    apply(lu);
    for (int i = 0; i < 65540; i++) tick(1'b0);
    st[0] = lu;                                                              ex[0] = 6'b000100;
    st[1] = lu;                                                              ex[1] = 6'b000100;
    st[2] = mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); ex[2] = 6'b000100;
    st[3] = '0;                                                              ex[3] = 6'b110000;
    st[4] = lu;                                                              ex[4] = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      sb.push_back('{$sformatf("counter_%0d", i), ex[i], exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
      total++;
      if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
      tick(e.ctrl[5]);
    end
    total++;
    if (stall_cycles !== 16'd1) begin bad++; $display("[TB] FAIL counter_after_clr cnt got=%h want=%h", stall_cycles, 16'd1); end
  endtask

  task automatic test_async_reset();
    stim_t      st[3];
    logic [5:0] ex[3];
    exp_t       e;
    apply('0);
    tick(1'b1);
    st[0] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ex[0] = 6'b110010;
    st[1] = '0;                                                              ex[1] = 6'b110001;
    st[2] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); ex[2] = 6'b000101;
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      sb.push_back('{$sformatf("mid_op_%0d", i), ex[i], exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
      total++;
      if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
      if (i < 2) tick(e.ctrl[5]);
    end
    #2;
    reset_n = 1'b0;
    sb.push_back('{"mid_op_reset", 6'b000100, 16'd0});
    #1;
    e = sb.pop_front();
    total++;
    if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
    total++;
    if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
    tick(1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{$sformatf("post_reset_%0d", i), 6'b110000, exp_cnt});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctrl_obs !== e.ctrl) begin bad++; $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl); end
      total++;
      if (stall_cycles !== e.cnt) begin bad++; $display("[TB] FAIL %s cnt got=%h want=%h", e.name, stall_cycles, e.cnt); end
      tick(e.ctrl[5]);
    end
  endtask

  // Bound on total run time in case the sequence stops advancing
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Feature tests in sequence, then the summary
  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch();
    test_counter();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
